// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional zero register, write-to-read bypass and busy scoreboard
module regfile_mp #(
  parameter int REG_W = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_IDX_W = $clog2(REG_COUNT),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [NUM_RD*REG_IDX_W-1:0] rd_reg,
  output logic [NUM_RD*REG_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*REG_IDX_W-1:0] wr_reg,
  input  logic [NUM_WR*REG_W-1:0]     wr_data,
  input  logic                        iss_en,
  input  logic [REG_IDX_W-1:0]        iss_reg
);
  logic [REG_W-1:0]     regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy, busy_nxt;
  logic [REG_IDX_W-1:0] wr_idx [NUM_WR];
  logic [NUM_WR-1:0]    wr_ok;
  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    assign wr_idx[i] = wr_reg[i*REG_IDX_W +: REG_IDX_W];
    assign wr_ok[i]  = wr_en[i] && !(ZERO_REG != 0 && wr_idx[i] == '0);
  end
  // an issue in the same cycle as a write re-marks the register busy
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j]) busy_nxt[wr_idx[j]] = 1'b0;
    if (iss_en) busy_nxt[iss_reg] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (!aresetn) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wr_ok[j]) regs[wr_idx[j]] <= wr_data[j*REG_W +: REG_W];
      busy <= busy_nxt;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_IDX_W-1:0] idx;
    logic [REG_W-1:0]     fwd;
    logic                 hit, zero;
    assign idx  = rd_reg[i*REG_IDX_W +: REG_IDX_W];
    assign zero = ZERO_REG != 0 && idx == '0;
    always_comb begin
      hit = 1'b0;
      fwd = regs[idx];
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS != 0 && wr_en[j] && wr_idx[j] == idx) begin
          hit = 1'b1;
          fwd = wr_data[j*REG_W +: REG_W];
        end
    end
    assign rd_data[i*REG_W +: REG_W] = zero ? '0 : fwd;
    assign rd_busy[i] = !zero && busy[idx] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, bypassing and non-bypassing instances on shared inputs
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data, nb_data;
  logic [1:0]  rd_busy, nb_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_reg;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_reg;
  int n_chk = 0, n_fail = 0;

  typedef struct {int sel; string tag; logic [31:0] v;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_mp dut (.clk(clk), .aresetn(aresetn), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .iss_en(iss_en), .iss_reg(iss_reg));
  regfile_mp #(.BYPASS(0)) dut_nb (.clk(clk), .aresetn(aresetn), .rd_reg(rd_reg), .rd_data(nb_data),
    .rd_busy(nb_busy), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .iss_en(iss_en), .iss_reg(iss_reg));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return rd_data[31:0];
      1: return rd_data[63:32];
      2: return {30'b0, rd_busy};
      3: return nb_data[31:0];
      default: return {30'b0, nb_busy};
    endcase
  endfunction

  task automatic push(input int sel, input string tag, input logic [31:0] v);
    q.push_back('{sel, tag, v});
  endtask

  // settle combinational outputs, drain expectations, then advance one clock
  task automatic step();
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, observe(e.sel), e.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    iss_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] r, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_reg[p*5 +: 5] = r;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_reg = {b, a};
  endtask

  initial begin
    aresetn = 1'b0; rd_reg = '0; wr_en = '0; wr_reg = '0; wr_data = '0; iss_en = 1'b0; iss_reg = '0;
    // 1: reset with concurrent writes and issue
    wr(0, 5'd3, 32'h33); wr(1, 5'd5, 32'h55); iss_en = 1'b1; iss_reg = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1; idle(); rd(5'd3, 5'd5);
    push(0, "rst_r3", 0); push(1, "rst_r5", 0); push(2, "rst_busy", 0);
    push(3, "rst_nb_r3", 0); push(4, "rst_nb_busy", 0);
    step();
    // 2: write r1..r31, bypass visible same cycle on the bypassing instance
    for (int i = 1; i < 32; i++) begin
      idle(); wr(0, 5'(i), 32'h100 + i); rd(5'(i), 5'(i));
      push(0, "wr_byp0", 32'h100 + i); push(1, "wr_byp1", 32'h100 + i); push(3, "wr_nb_old", 0);
      step();
    end
    idle(); wr(0, 5'd0, 32'hDEAD); rd(5'd0, 5'd0);
    push(0, "r0_byp", 0); push(3, "r0_nb", 0);
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      push(0, "rdall0", i == 0 ? 0 : 32'h100 + i);
      push(1, "rdall1", i == 31 ? 0 : 32'h100 + 31 - i);
      push(3, "rdall_nb", i == 0 ? 0 : 32'h100 + i);
      step();
    end
    // 3: same-register conflict, port 1 wins
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(5'd7, 5'd7);
    push(0, "conf_byp", 32'h22); push(3, "conf_nb_old", 32'h107);
    step();
    idle();
    push(0, "conf_after", 32'h22); push(3, "conf_nb_after", 32'h22);
    step();
    // two ports to distinct registers
    wr(0, 5'd20, 32'hA0); wr(1, 5'd21, 32'hA1); rd(5'd20, 5'd21);
    push(0, "dual0", 32'hA0); push(1, "dual1", 32'hA1);
    step();
    idle();
    push(3, "dual_nb", 32'hA0);
    step();
    // 4: bypass on/off
    wr(0, 5'd9, 32'hABCD); rd(5'd9, 5'd9);
    push(0, "byp_same", 32'hABCD); push(3, "nb_same_old", 32'h109);
    step();
    idle();
    push(3, "nb_next", 32'hABCD);
    step();
    // 5: scoreboard
    iss_en = 1'b1; iss_reg = 5'd4; rd(5'd4, 5'd0);
    push(2, "iss_not_yet", 0);
    step();
    idle();
    push(2, "iss_busy", 2'b01); push(4, "iss_nb_busy", 2'b01);
    step();
    wr(1, 5'd4, 32'h55);
    push(2, "wb_busy_clr", 0); push(0, "wb_data", 32'h55);
    push(4, "wb_nb_busy", 2'b01); push(3, "wb_nb_old", 32'h104);
    step();
    idle();
    push(2, "after_wb", 0); push(4, "after_wb_nb", 0); push(3, "after_wb_nb_d", 32'h55);
    step();
    wr(0, 5'd4, 32'h66); iss_en = 1'b1; iss_reg = 5'd4;
    push(0, "isswr_data", 32'h66);
    step();
    idle();
    push(2, "isswr_busy", 2'b01); push(4, "isswr_nb_busy", 2'b01); push(0, "isswr_stored", 32'h66);
    step();
    iss_en = 1'b1; iss_reg = 5'd0; rd(5'd0, 5'd4);
    step();
    idle();
    push(2, "iss_r0", 2'b10); push(0, "r0_zero", 0);
    step();
    // 6: reset mid-flight
    iss_en = 1'b1; iss_reg = 5'd12; step();
    iss_reg = 5'd13; step();
    idle(); rd(5'd12, 5'd13);
    push(2, "pre_rst_busy", 2'b11); push(0, "pre_rst_r12", 32'h10C);
    step();
    aresetn = 1'b0; wr(0, 5'd12, 32'h77); iss_en = 1'b1; iss_reg = 5'd14;
    step();
    aresetn = 1'b1; idle();
    push(2, "mid_rst_busy", 0); push(0, "mid_rst_r12", 0); push(1, "mid_rst_r13", 0);
    push(4, "mid_rst_nb_busy", 0); push(3, "mid_rst_nb_r12", 0);
    step();
    rd(5'd14, 5'd1);
    push(2, "mid_rst_iss14", 0); push(1, "mid_rst_r1", 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
